// File: rtl/cmac_link_monitor.sv
// Multi-channel CMAC link supervisor.
// Brings the GT lock / RX alignment / data-fail status of each CMAC into init_clk,
// runs an independent link state machine per channel, issues lbus_tx_rx_restart
// pulses when alignment does not arrive in time, and escalates to a sticky FAULT
// once the retry budget of the current attempt is used up. Saturating loss-of-link
// and data-fail counters are kept per channel for register/ILA readout.
module cmac_link_monitor #(
   parameter int NUM_CH            = 2,
   parameter int CNT_W             = 16,
   parameter int UP_HOLD_CYC       = 1000,
   parameter int ALIGN_TIMEOUT_CYC = 100000000,
   parameter int MAX_RESTARTS      = 3,
   parameter int RESTART_PULSE_CYC = 16
) (
   input  logic                      init_clk,
   input  logic                      sys_reset_n,
   input  logic [NUM_CH-1:0]         ch_enable,
   input  logic [NUM_CH-1:0]         gt_locked_in,
   input  logic [NUM_CH-1:0]         rx_aligned_in,
   input  logic [NUM_CH-1:0]         rx_data_fail_in,
   input  logic                      clr_counts,
   output logic [NUM_CH-1:0]         restart_out,
   output logic [NUM_CH-1:0]         link_up,
   output logic [NUM_CH-1:0]         link_fault,
   output logic [2*NUM_CH-1:0]       ch_state,
   output logic [CNT_W*NUM_CH-1:0]   loss_count,
   output logic [CNT_W*NUM_CH-1:0]   fail_count,
   output logic                      any_fault
);

   localparam logic [1:0] ST_DOWN  = 2'b00;
   localparam logic [1:0] ST_WAIT  = 2'b01;
   localparam logic [1:0] ST_UP    = 2'b10;
   localparam logic [1:0] ST_FAULT = 2'b11;

   localparam int TMR_W  = (ALIGN_TIMEOUT_CYC > 1) ? $clog2(ALIGN_TIMEOUT_CYC) : 1;
   localparam int HOLD_W = $clog2(UP_HOLD_CYC + 1);
   localparam int RTY_W  = (MAX_RESTARTS > 0) ? $clog2(MAX_RESTARTS + 1) : 1;
   localparam int PLS_W  = $clog2(RESTART_PULSE_CYC + 1);

   localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(ALIGN_TIMEOUT_CYC - 1);
   localparam logic [HOLD_W-1:0] HOLD_DONE = HOLD_W'(UP_HOLD_CYC);
   localparam logic [RTY_W-1:0]  RTY_MAX   = RTY_W'(MAX_RESTARTS);
   localparam logic [PLS_W-1:0]  PLS_LEN   = PLS_W'(RESTART_PULSE_CYC);

   // Event counters stick at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   // Counter update: clear has priority over a coincident increment.
   function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] v,
                                                 input logic inc, input logic clr);
      if (clr)      return '0;
      else if (inc) return sat_inc(v);
      else          return v;
   endfunction

   logic [NUM_CH-1:0] locked_p0, locked_s;
   logic [NUM_CH-1:0] aligned_p0, aligned_s;
   logic [NUM_CH-1:0] fail_p0, fail_s, fail_s_d;
   logic [NUM_CH-1:0] fault_nxt;

   // Stage p0 -> s: two-flop synchronisers, plus one extra flop for data-fail edge detect.
   always_ff @(posedge init_clk) begin
      if (!sys_reset_n) begin
         locked_p0  <= '0;
         locked_s   <= '0;
         aligned_p0 <= '0;
         aligned_s  <= '0;
         fail_p0    <= '0;
         fail_s     <= '0;
         fail_s_d   <= '0;
      end else begin
         locked_p0  <= gt_locked_in;
         locked_s   <= locked_p0;
         aligned_p0 <= rx_aligned_in;
         aligned_s  <= aligned_p0;
         fail_p0    <= rx_data_fail_in;
         fail_s     <= fail_p0;
         fail_s_d   <= fail_s;
      end
   end

   // Summary fault flag, registered from the same next-state as each link_fault.
   always_ff @(posedge init_clk) begin
      if (!sys_reset_n) any_fault <= 1'b0;
      else              any_fault <= |fault_nxt;
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic [1:0]        st_q,   st_d;
      logic [TMR_W-1:0]  tmr_q,  tmr_d;
      logic [HOLD_W-1:0] hold_q, hold_d;
      logic [RTY_W-1:0]  rty_q,  rty_d;
      logic [PLS_W-1:0]  pls_q,  pls_d;
      logic              loss_inc, fail_inc;
      logic [CNT_W-1:0]  loss_q, fail_q;
      logic              restart_q, up_q, fault_q;

      assign fail_inc = (st_q == ST_UP) && fail_s[i] && !fail_s_d[i];

      // Link state machine next-state; restart pulse exists only while waiting for alignment.
      always_comb begin
         st_d     = st_q;
         tmr_d    = tmr_q;
         hold_d   = hold_q;
         rty_d    = rty_q;
         pls_d    = (pls_q != '0) ? pls_q - PLS_W'(1) : '0;
         loss_inc = 1'b0;
         case (st_q)
            ST_DOWN: begin
               tmr_d  = '0;
               hold_d = '0;
               rty_d  = '0;
               pls_d  = '0;
               if (ch_enable[i] && locked_s[i]) st_d = ST_WAIT;
            end
            ST_WAIT: begin
               if (!ch_enable[i] || !locked_s[i]) begin
                  st_d   = ST_DOWN;
                  tmr_d  = '0;
                  hold_d = '0;
                  rty_d  = '0;
                  pls_d  = '0;
               end else if (hold_q == HOLD_DONE) begin
                  // Hold completion beats a timeout landing in the same cycle.
                  st_d   = ST_UP;
                  tmr_d  = '0;
                  hold_d = '0;
                  rty_d  = '0;
                  pls_d  = '0;
               end else begin
                  hold_d = aligned_s[i] ? hold_q + HOLD_W'(1) : '0;
                  if (pls_q != '0) begin
                     // The CMAC is being restarted; the timeout restarts after the pulse.
                     tmr_d = '0;
                  end else if (tmr_q == TMR_LAST) begin
                     tmr_d = '0;
                     if (rty_q < RTY_MAX) begin
                        rty_d = rty_q + RTY_W'(1);
                        pls_d = PLS_LEN;
                     end else begin
                        st_d = ST_FAULT;
                     end
                  end else begin
                     tmr_d = tmr_q + TMR_W'(1);
                  end
               end
            end
            ST_UP: begin
               pls_d = '0;
               if (!aligned_s[i] || !locked_s[i] || !ch_enable[i]) begin
                  st_d     = ST_DOWN;
                  loss_inc = 1'b1;
               end
            end
            default: begin
               // FAULT is sticky until software disables the channel.
               pls_d = '0;
               if (!ch_enable[i]) begin
                  st_d  = ST_DOWN;
                  rty_d = '0;
               end
            end
         endcase
      end

      assign fault_nxt[i] = (st_d == ST_FAULT);

      // State, timers, counters and registered per-channel outputs.
      always_ff @(posedge init_clk) begin
         if (!sys_reset_n) begin
            st_q      <= ST_DOWN;
            tmr_q     <= '0;
            hold_q    <= '0;
            rty_q     <= '0;
            pls_q     <= '0;
            loss_q    <= '0;
            fail_q    <= '0;
            restart_q <= 1'b0;
            up_q      <= 1'b0;
            fault_q   <= 1'b0;
         end else begin
            st_q      <= st_d;
            tmr_q     <= tmr_d;
            hold_q    <= hold_d;
            rty_q     <= rty_d;
            pls_q     <= pls_d;
            loss_q    <= cnt_next(loss_q, loss_inc, clr_counts);
            fail_q    <= cnt_next(fail_q, fail_inc, clr_counts);
            restart_q <= (pls_d != '0);
            up_q      <= (st_d == ST_UP);
            fault_q   <= (st_d == ST_FAULT);
         end
      end

      assign restart_out[i]                 = restart_q;
      assign link_up[i]                     = up_q;
      assign link_fault[i]                  = fault_q;
      assign ch_state[2*i +: 2]             = st_q;
      assign loss_count[CNT_W*i +: CNT_W]   = loss_q;
      assign fail_count[CNT_W*i +: CNT_W]   = fail_q;
   end

endmodule
